// File: rtl/fb_port_if.sv
// Bundle of the display-read, camera-write, status and BRAM-side signals around
// the frame-buffer port arbiter; slave is the arbiter side, master the surroundings.
interface fb_port_if #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
);
    logic                     rd_req;
    logic [c_nb_img_pxls-1:0] rd_addr;
    logic [c_nb_buf-1:0]      rd_data;
    logic                     rd_valid;
    logic                     wr_valid;
    logic [c_nb_img_pxls-1:0] wr_addr;
    logic [c_nb_buf-1:0]      wr_data;
    logic                     wr_ready;
    logic                     clr_ovf;
    logic                     ovf;
    logic [7:0]               drop_cnt;
    logic [c_nb_img_pxls-1:0] mem_addr;
    logic                     mem_we;
    logic [c_nb_buf-1:0]      mem_wdata;
    logic [c_nb_buf-1:0]      mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_ovf, mem_rdata,
        output rd_data, rd_valid, wr_ready, ovf, drop_cnt, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_ovf, mem_rdata,
        input  rd_data, rd_valid, wr_ready, ovf, drop_cnt, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win with fixed 2-cycle
// latency, camera writes are queued in a small FIFO and drained on idle cycles.
module fb_port_arbiter #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_wfifo    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    fb_port_if.slave   bus
);
    localparam int DEPTH = 1 << c_nb_wfifo;
    localparam logic [c_nb_wfifo:0]   CNT_ONE  = (c_nb_wfifo+1)'(1);
    localparam logic [c_nb_wfifo:0]   CNT_FULL = (c_nb_wfifo+1)'(DEPTH);
    localparam logic [c_nb_wfifo-1:0] PTR_ONE  = c_nb_wfifo'(1);

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} grant_e;
    grant_e grant;

    logic [c_nb_img_pxls-1:0] fifo_addr_q [DEPTH];
    logic [c_nb_buf-1:0]      fifo_data_q [DEPTH];
    logic [c_nb_wfifo:0]      cnt_q, cnt_d;
    logic [c_nb_wfifo-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                     push, pop, drop, wr_ready;

    logic [c_nb_img_pxls-1:0] mem_addr_q, mem_addr_d;
    logic [c_nb_buf-1:0]      mem_wdata_q, mem_wdata_d;
    logic                     mem_we_q, mem_we_d;

    logic                     rd_p1_q, rd_p1_d, rd_p2_q, rd_valid_q;
    logic [c_nb_buf-1:0]      rd_data_q;

    logic                     ovf_q, ovf_d;
    logic [7:0]               drop_cnt_q, drop_cnt_d;

    assign wr_ready = (cnt_q != CNT_FULL);

    always_comb begin
        grant       = IDLE;
        push        = bus.wr_valid & wr_ready;
        drop        = bus.wr_valid & ~wr_ready;
        pop         = 1'b0;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rd_p1_d     = 1'b0;
        ovf_d       = ovf_q;
        drop_cnt_d  = drop_cnt_q;

        if (bus.rd_req)
            grant = GRANT_RD;
        else if (cnt_q != '0)
            grant = GRANT_WR;

        case (grant)
            GRANT_RD: begin
                mem_addr_d = bus.rd_addr;
                rd_p1_d    = 1'b1;
            end
            GRANT_WR: begin
                pop         = 1'b1;
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_data_q[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
            default: ;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push)
            cnt_d = cnt_q - CNT_ONE;

        // Clear wins over a drop landing in the same cycle.
        if (bus.clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            // BRAM samples the address while the flag moves p1 -> p2.
            rd_p1_q     <= rd_p1_d;
            rd_p2_q     <= rd_p1_q;
            rd_valid_q  <= rd_p2_q;
            if (rd_p2_q) rd_data_q <= bus.mem_rdata;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
            fifo_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a read-first 1-cycle BRAM model.
module tb_fb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    logic [11:0] mem [0:8191];

    fb_port_if #(.c_nb_img_pxls(13), .c_nb_buf(12)) bus ();

    fb_port_arbiter #(.c_nb_img_pxls(13), .c_nb_buf(12), .c_nb_wfifo(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end

    function automatic logic [11:0] init_val(input int a);
        return 12'(a * 5 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_ovf  = 1'b0;
    endtask

    initial begin
        int we_seen;
        for (int i = 0; i < 8192; i++) mem[i] = init_val(i);
        mem[13'h12A] = 12'hF0F;
        bus.mem_rdata = '0;
        idle_inputs();

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req   = 1'($urandom);
            bus.rd_addr  = 13'($urandom);
            bus.wr_valid = 1'($urandom);
            bus.wr_addr  = 13'($urandom);
            bus.wr_data  = 12'($urandom);
            bus.clr_ovf  = 1'($urandom);
            tick();
            chk("rst_rd_data",   32'(bus.rd_data),   32'h0);
            chk("rst_rd_valid",  32'(bus.rd_valid),  32'h0);
            chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
            chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
            chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
            chk("rst_ovf",       32'(bus.ovf),       32'h0);
            chk("rst_drop_cnt",  32'(bus.drop_cnt),  32'h0);
            chk("rst_wr_ready",  32'(bus.wr_ready),  32'h1);
        end
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_mem_we", 32'(bus.mem_we), 32'h0);
        end

        // Single read
        bus.rd_req  = 1'b1;
        bus.rd_addr = 13'h12A;
        tick();
        chk("single_mem_addr", 32'(bus.mem_addr), 32'h12A);
        chk("single_mem_we",   32'(bus.mem_we),   32'h0);
        chk("single_vld_k0",   32'(bus.rd_valid), 32'h0);
        bus.rd_req = 1'b0;
        tick();
        chk("single_vld_k1", 32'(bus.rd_valid), 32'h0);
        tick();
        chk("single_vld_k2", 32'(bus.rd_valid), 32'h1);
        chk("single_data",   32'(bus.rd_data),  32'hF0F);
        tick();
        chk("single_vld_k3", 32'(bus.rd_valid), 32'h0);

        // Read priority: 3 queued writes wait behind 4 back-to-back reads
        for (int c = 0; c < 7; c++) begin
            bus.rd_req   = (c < 4);
            bus.rd_addr  = 13'(16 + c);
            bus.wr_valid = (c < 3);
            bus.wr_addr  = 13'(256 + c);
            bus.wr_data  = 12'(12'hA00 + c);
            tick();
            if (c < 4) begin
                chk("prio_rd_we",   32'(bus.mem_we),   32'h0);
                chk("prio_rd_addr", 32'(bus.mem_addr), 32'(16 + c));
            end else begin
                chk("prio_wr_we",    32'(bus.mem_we),    32'h1);
                chk("prio_wr_addr",  32'(bus.mem_addr),  32'(256 + c - 4));
                chk("prio_wr_wdata", 32'(bus.mem_wdata), 32'(12'hA00 + c - 4));
            end
            chk("prio_rd_valid", 32'(bus.rd_valid), 32'((c >= 2) && (c <= 5)));
            if (c >= 2 && c <= 5)
                chk("prio_rd_data", 32'(bus.rd_data), 32'(init_val(16 + c - 2)));
            chk("prio_wr_ready", 32'(bus.wr_ready), 32'h1);
        end
        idle_inputs();
        tick();
        chk("prio_drained", 32'(bus.mem_we), 32'h0);

        // FIFO full / overflow under a continuous read stream
        bus.rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 13'(512 + i);
            bus.wr_data  = 12'(12'h300 + i);
            tick();
            chk("ovf_no_we", 32'(bus.mem_we), 32'h0);
        end
        bus.wr_valid = 1'b0;
        chk("ovf_wr_ready", 32'(bus.wr_ready), 32'h0);
        chk("ovf_flag",     32'(bus.ovf),      32'h1);
        chk("ovf_drops",    32'(bus.drop_cnt), 32'h2);
        bus.rd_req = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.mem_we) begin
                chk("ovf_drain_addr",  32'(bus.mem_addr),  32'(512 + we_seen));
                chk("ovf_drain_wdata", 32'(bus.mem_wdata), 32'(12'h300 + we_seen));
                we_seen++;
            end
        end
        chk("ovf_we_count",   32'(we_seen),      32'h4);
        chk("ovf_ready_back", 32'(bus.wr_ready), 32'h1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("clr_ovf",      32'(bus.ovf),      32'h0);
        chk("clr_drop_cnt", 32'(bus.drop_cnt), 32'h0);

        // Saturation and clear priority
        bus.rd_req   = 1'b1;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_full", 32'(bus.wr_ready), 32'h0);
        for (int i = 0; i < 300; i++) tick();
        chk("sat_drop_cnt", 32'(bus.drop_cnt), 32'hFF);
        chk("sat_ovf",      32'(bus.ovf),      32'h1);
        bus.clr_ovf = 1'b1;
        tick();
        chk("clrprio_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        chk("clrprio_ovf",      32'(bus.ovf),      32'h0);
        bus.clr_ovf = 1'b0;
        tick();
        chk("after_clr_drop_cnt", 32'(bus.drop_cnt), 32'h1);
        chk("after_clr_ovf",      32'(bus.ovf),      32'h1);
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("sat_cleanup_ready", 32'(bus.wr_ready), 32'h1);

        // Reset mid-operation with a read in flight and a write queued
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 13'h12A;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 13'h0AA;
        bus.wr_data  = 12'h555;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("midrst_wr_ready", 32'(bus.wr_ready), 32'h1);
        chk("midrst_mem_we",   32'(bus.mem_we),   32'h0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_rd_valid", 32'(bus.rd_valid), 32'h0);
            chk("postrst_mem_we",   32'(bus.mem_we),   32'h0);
            chk("postrst_wr_ready", 32'(bus.wr_ready), 32'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
